// File: rtl/vram_sdram_pkg.sv
// Shared types for the VDP-side SDRAM requester: FSM states, the buffered
// request record and the byte-enable to write-mask mapping.
package vram_sdram_pkg;

    localparam int REQ_ADDR_WIDTH = 23;

    typedef enum logic [1:0] {
        WAIT_EN,
        IDLE,
        BUSY
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [15:0]               wdata;
        logic [1:0]                be;
    } req_t;

    // A request with no byte enabled is treated as a full halfword write.
    function automatic logic [1:0] be_to_wdm(input logic [1:0] be);
        return (be == 2'b00) ? 2'b11 : be;
    endfunction

endpackage

// File: rtl/refresh_timer.sv
// Free-running auto-refresh interval counter with a pending request flag and
// a sticky overrun flag for intervals that expire before the last was served.
module refresh_timer #(
    parameter int REFRESH_CYCLES = 800
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic pending,
    output logic overrun
);

    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] count;
    logic          wrap;

    assign wrap = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (run) begin
                count <= wrap ? '0 : count + 1'b1;
            end
            if (wrap) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
            // A wrap that coincides with serving the old refresh is not an overrun.
            if (wrap && pending && !clear) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_sdram_requester.sv
// Single-entry VRAM request buffer in front of the SDRAM controller; issues
// reads, writes and periodic auto-refresh and returns the selected read halfword.
module vram_sdram_requester
    import vram_sdram_pkg::*;
#(
    parameter int FREQ           = 54_000_000,
    parameter int REFRESH_CYCLES = 800,
    parameter int ADDR_WIDTH     = REQ_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_wdata,
    input  logic [1:0]            req_be,
    output logic [15:0]           rdata,
    output logic                  rdata_valid,
    output logic                  refresh_overrun,
    output logic                  sdram_rd,
    output logic                  sdram_wr,
    output logic                  sdram_refresh,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [15:0]           sdram_din,
    output logic [1:0]            sdram_wdm,
    input  logic [31:0]           sdram_dout32,
    input  logic                  sdram_data_ready,
    input  logic                  sdram_busy,
    input  logic                  sdram_enabled
);

    localparam longint REFRESH_NS = (longint'(REFRESH_CYCLES) * 64'd1_000_000_000) / longint'(FREQ);

    generate
        if (REFRESH_NS >= 15_000) begin : g_refresh_too_slow
            $error("REFRESH_CYCLES exceeds the 15 us refresh interval at FREQ");
        end
        if (ADDR_WIDTH != REQ_ADDR_WIDTH) begin : g_addr_width_mismatch
            $error("ADDR_WIDTH must match the request record address width");
        end
    endgenerate

    state_t state, state_next;
    req_t   buf_q;
    logic   buf_full;
    logic   ref_pending;
    logic   issue_ref, issue_req, can_issue, cmd_cycle;
    logic   rd_wait, rd_sel_hi;

    assign req_ready = (state != WAIT_EN) && !buf_full;
    assign cmd_cycle = sdram_rd | sdram_wr | sdram_refresh;

    refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk    (clk),
        .resetn (resetn),
        .run    (state != WAIT_EN),
        .clear  (issue_ref),
        .pending(ref_pending),
        .overrun(refresh_overrun)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= WAIT_EN;
        end else begin
            state <= state_next;
        end
    end

    // The controller only raises busy the cycle after a command, so the strobe
    // cycle itself must not be taken as the end of the BUSY wait.
    always_comb begin
        state_next = state;
        can_issue  = 1'b0;
        issue_ref  = 1'b0;
        issue_req  = 1'b0;
        case (state)
            WAIT_EN: if (sdram_enabled && !sdram_busy) state_next = IDLE;
            IDLE:    can_issue = !sdram_busy;
            BUSY: begin
                if (!cmd_cycle && !sdram_busy) begin
                    can_issue  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = WAIT_EN;
        endcase
        if (can_issue) begin
            if (ref_pending) begin
                issue_ref = 1'b1;
            end else if (buf_full) begin
                issue_req = 1'b1;
            end
        end
        if (issue_ref || issue_req) begin
            state_next = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_q         <= '0;
            buf_full      <= 1'b0;
            sdram_rd      <= 1'b0;
            sdram_wr      <= 1'b0;
            sdram_refresh <= 1'b0;
            sdram_addr    <= '0;
            sdram_din     <= '0;
            sdram_wdm     <= '0;
            rd_wait       <= 1'b0;
            rd_sel_hi     <= 1'b0;
            rdata         <= '0;
            rdata_valid   <= 1'b0;
        end else begin
            sdram_refresh <= issue_ref;
            sdram_rd      <= issue_req && !buf_q.we;
            sdram_wr      <= issue_req && buf_q.we;
            rdata_valid   <= 1'b0;
            if (issue_req) begin
                sdram_addr <= buf_q.addr;
                sdram_din  <= buf_q.wdata;
                sdram_wdm  <= be_to_wdm(buf_q.be);
                buf_full   <= 1'b0;
            end else if (req_valid && req_ready) begin
                buf_q    <= '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                buf_full <= 1'b1;
            end
            // The controller returns a 32-bit word; addr[0] picks the halfword.
            if (issue_req && !buf_q.we) begin
                rd_wait   <= 1'b1;
                rd_sel_hi <= buf_q.addr[0];
            end else if (sdram_data_ready && rd_wait) begin
                rd_wait     <= 1'b0;
                rdata       <= rd_sel_hi ? sdram_dout32[31:16] : sdram_dout32[15:0];
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_sdram_requester.sv
// Directed bench for vram_sdram_requester with a small SDRAM controller model.
module tb_vram_sdram_requester;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic [15:0] rdata;
    logic        rdata_valid, refresh_overrun;
    logic        sdram_rd, sdram_wr, sdram_refresh;
    logic [22:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_wdm;
    logic [31:0] sdram_dout32;
    logic        sdram_data_ready, sdram_busy, sdram_enabled;

    logic        hold_busy;
    logic [31:0] mem_word;
    logic [2:0]  rd_pipe = '0;
    int          busy_cnt = 0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0, rd_count = 0, ref_count = 0, rdv_count = 0;
    int last_rd_time = 0, last_ref_time = 0, prev_ref_time = 0, last_rdv_time = 0;
    logic [22:0] last_wr_addr;
    logic [15:0] last_wr_din, last_rdata;
    logic [1:0]  last_wr_wdm;

    localparam int C_WR = 0, C_RD = 1, C_REF = 2, C_RDV = 3;

    always #5 clk = ~clk;

    vram_sdram_requester dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_be          (req_be),
        .rdata           (rdata),
        .rdata_valid     (rdata_valid),
        .refresh_overrun (refresh_overrun),
        .sdram_rd        (sdram_rd),
        .sdram_wr        (sdram_wr),
        .sdram_refresh   (sdram_refresh),
        .sdram_addr      (sdram_addr),
        .sdram_din       (sdram_din),
        .sdram_wdm       (sdram_wdm),
        .sdram_dout32    (sdram_dout32),
        .sdram_data_ready(sdram_data_ready),
        .sdram_busy      (sdram_busy),
        .sdram_enabled   (sdram_enabled)
    );

    // Controller model: busy for 4 cycles after any command, read data 3 cycles after rd.
    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[1:0], sdram_rd};
        if (sdram_rd || sdram_wr || sdram_refresh) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign sdram_busy       = (busy_cnt != 0) || hold_busy;
    assign sdram_data_ready = rd_pipe[2];
    assign sdram_dout32     = mem_word;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sdram_wr) begin
            wr_count++;
            last_wr_addr = sdram_addr;
            last_wr_din  = sdram_din;
            last_wr_wdm  = sdram_wdm;
        end
        if (sdram_rd) begin
            rd_count++;
            last_rd_time = cyc;
        end
        if (sdram_refresh) begin
            ref_count++;
            prev_ref_time = last_ref_time;
            last_ref_time = cyc;
        end
        if (rdata_valid) begin
            rdv_count++;
            last_rdv_time = cyc;
            last_rdata    = rdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int counterValue(input int sel);
        case (sel)
            C_WR:    return wr_count;
            C_RD:    return rd_count;
            C_REF:   return ref_count;
            default: return rdv_count;
        endcase
    endfunction

    task automatic waitEvent(input string tag, input int sel, input int base, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            if (counterValue(sel) > base) break;
        end
        checkOutput(tag, 32'(counterValue(sel) > base), 1);
    endtask

    task automatic applyStimulus(input logic we, input logic [22:0] addr,
                                 input logic [15:0] wdata, input logic [1:0] be);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_we    = we;
                req_addr  = addr;
                req_wdata = wdata;
                req_be    = be;
                req_valid = 1'b1;
                @(posedge clk);
                #1 req_valid = 1'b0;
                done = 1;
            end
        end
        checkOutput("req_accept", 32'(done), 1);
    endtask

    initial begin
        logic [1:0] be_vec [3];
        logic [1:0] wdm_vec[3];
        int base_a, base_b;
        be_vec  = '{2'b01, 2'b00, 2'b10};
        wdm_vec = '{2'b01, 2'b11, 2'b10};

        resetn = 1'b0; sdram_enabled = 1'b0; hold_busy = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        mem_word = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_cmds", {sdram_rd, sdram_wr, sdram_refresh}, 0);
        checkOutput("rst_rdv_ovr", {rdata_valid, refresh_overrun}, 0);
        checkOutput("rst_addr_wdm", {sdram_addr, sdram_wdm}, 0);
        resetn = 1'b1;

        repeat (50) @(negedge clk);
        checkOutput("waiten_ready", req_ready, 0);
        checkOutput("waiten_no_cmds", wr_count + rd_count + ref_count, 0);
        sdram_enabled = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checkOutput("powerup_ready", req_ready, 1);
        repeat (5) @(negedge clk);

        applyStimulus(1'b1, 23'h000123, 16'hBEEF, 2'b11);
        @(negedge clk); @(negedge clk);
        checkOutput("wr_strobe", sdram_wr, 1);
        checkOutput("wr_addr", sdram_addr, 23'h000123);
        checkOutput("wr_din", sdram_din, 16'hBEEF);
        checkOutput("wr_wdm", sdram_wdm, 2'b11);
        repeat (10) @(negedge clk);
        checkOutput("wr_single_pulse", wr_count, 1);

        mem_word = 32'hBEEF_0000;
        base_a = rdv_count;
        applyStimulus(1'b0, 23'h000123, 16'h0000, 2'b11);
        waitEvent("rd_hi_return", C_RDV, base_a, 50);
        checkOutput("rd_hi_data", last_rdata, 16'hBEEF);
        checkOutput("rd_latency", last_rdv_time - last_rd_time, 4);
        repeat (10) @(negedge clk);
        checkOutput("rd_single_pulse", rdv_count - base_a, 1);

        mem_word = 32'h1234_5678;
        base_a = rdv_count;
        applyStimulus(1'b0, 23'h000124, 16'h0000, 2'b11);
        waitEvent("rd_lo_return", C_RDV, base_a, 50);
        checkOutput("rd_lo_data", last_rdata, 16'h5678);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            base_a = wr_count;
            applyStimulus(1'b1, 23'h000040 + 23'(i), 16'h00A5, be_vec[i]);
            waitEvent("byte_wr_issue", C_WR, base_a, 50);
            checkOutput("byte_wr_wdm", last_wr_wdm, wdm_vec[i]);
            repeat (8) @(negedge clk);
        end

        base_a = ref_count;
        repeat (2400) @(posedge clk);
        checkOutput("ref_cadence_count", ref_count - base_a, 3);
        checkOutput("ref_spacing", last_ref_time - prev_ref_time, 800);
        checkOutput("ref_no_overrun", refresh_overrun, 0);

        base_a = ref_count;
        waitEvent("ref_sync", C_REF, base_a, 900);
        @(negedge clk);
        hold_busy = 1'b1;
        mem_word  = 32'h5555_AAAA;
        base_a = rd_count;
        base_b = ref_count;
        applyStimulus(1'b0, 23'h000200, 16'h0000, 2'b11);
        repeat (805) @(posedge clk);
        checkOutput("hold_no_cmds", (rd_count - base_a) + (ref_count - base_b), 0);
        @(negedge clk);
        hold_busy = 1'b0;
        waitEvent("coll_rd_return", C_RDV, rdv_count, 60);
        checkOutput("coll_ref_once", ref_count - base_b, 1);
        checkOutput("coll_rd_once", rd_count - base_a, 1);
        checkOutput("coll_order_gap", last_rd_time - last_ref_time, 6);
        checkOutput("coll_rdata", last_rdata, 16'hAAAA);
        checkOutput("coll_no_overrun", refresh_overrun, 0);

        base_a = ref_count;
        waitEvent("ref_sync2", C_REF, base_a, 900);
        @(negedge clk);
        hold_busy = 1'b1;
        base_a = ref_count;
        repeat (1700) @(posedge clk);
        checkOutput("ovr_no_refresh", ref_count - base_a, 0);
        @(negedge clk);
        checkOutput("ovr_flag", refresh_overrun, 1);
        hold_busy = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("ovr_sticky", refresh_overrun, 1);

        mem_word = 32'hDEAD_BEEF;
        base_a = rdv_count;
        applyStimulus(1'b0, 23'h000300, 16'h0000, 2'b11);
        @(negedge clk); @(negedge clk);
        checkOutput("midrd_issued", sdram_rd, 1);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrd_rst_ready", req_ready, 0);
        checkOutput("midrd_rst_cmds", {sdram_rd, sdram_wr, sdram_refresh}, 0);
        checkOutput("midrd_rst_flags", {rdata_valid, refresh_overrun}, 0);
        checkOutput("midrd_rst_data", {sdram_addr, sdram_din, rdata}, 0);
        resetn = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("midrd_no_rdv", rdv_count - base_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
